seq_detect_counter: RTL and testbench

- Serial pattern detector stage that consumes the q output of the synchronous-reset D flip-flop (the registered serial bit stream).
- Tracks a programmable 4-bit pattern (MSB first), emits a one-cycle match pulse, and keeps a saturating count of matches.
- Feeds status/LED logic downstream. Single clock domain.

---
 rtl/seq_detect_counter.sv | 124 ++++++++++++
 tb/tb_seq_detect_counter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seq_detect_counter.sv
// Serial pattern detector: tracks a programmable 4-bit pattern (MSB first) with a
// KMP-style prefix FSM, pulses match for one cycle and keeps a saturating match count.
module seq_detect_counter #(
  parameter logic [3:0] PATTERN = 4'b1011,
  parameter int         CNT_W   = 4,
  parameter bit         OVERLAP = 1'b1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             din,
  input  logic             en,
  output logic             match,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Longest l <= n such that the l newest bits of seq (seq[0] newest) equal pat[3:4-l].
  function automatic logic [2:0] prefix_len(input logic [4:0] seq, input logic [2:0] n,
                                            input logic [3:0] pat);
    logic [2:0] best;
    logic       ok;
    logic [1:0] pidx;
    logic [2:0] sidx;
    best = 3'd0;
    for (int l = 1; l <= 4; l++) begin
      ok = 1'b1;
      for (int j = 0; j < l; j++) begin
        pidx = 2'(4 - l + j);
        sidx = 3'(j);
        if (seq[sidx] != pat[pidx]) begin
          ok = 1'b0;
        end else begin
          ok = ok;
        end
      end
      if (ok && (l <= int'(n))) begin
        best = 3'(l);
      end else begin
        best = best;
      end
    end
    return best;
  endfunction

  // Rebuild the k matched prefix bits followed by the new bit, then find the fallback length.
  function automatic logic [2:0] next_len(input logic [1:0] k, input logic d,
                                          input logic [3:0] pat);
    logic [4:0] seq;
    logic [1:0] pidx;
    seq = {4'b0000, d};
    for (int j = 1; j <= 3; j++) begin
      if (j <= int'(k)) begin
        pidx = 2'(3 - int'(k) + j);
        seq[3'(j)] = pat[pidx];
      end else begin
        seq[3'(j)] = 1'b0;
      end
    end
    return prefix_len(seq, {1'b0, k} + 3'd1, pat);
  endfunction

  localparam logic [1:0] BORDER = 2'(prefix_len({1'b0, PATTERN}, 3'd3, PATTERN));

  state_e           state_q, state_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic [2:0]       len_s;

  // Next-state, match pulse and saturating counter update.
  always_comb begin
    state_d = state_q;
    match_d = 1'b0;
    count_d = count_q;
    sat_d   = sat_q;
    len_s   = 3'd0;
    if (en) begin
      len_s = next_len(state_q, din, PATTERN);
      if (len_s == 3'd4) begin
        match_d = 1'b1;
        state_d = OVERLAP ? state_e'(BORDER) : S0;
        if (count_q != CNT_MAX) begin
          count_d = count_q + CNT_W'(1);
          sat_d   = sat_q | (count_d == CNT_MAX);
        end else begin
          count_d = count_q;
        end
      end else begin
        state_d = state_e'(len_s[1:0]);
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= S0;
      match_q <= 1'b0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign match = match_q;
  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: tb/tb_seq_detect_counter.sv
// Scoreboard bench: directed stimulus pushes hand-computed expectations, a monitor
// pops one per clock and compares the selected detector instance.
module tb_seq_detect_counter;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic din = 1'b0;
  logic en  = 1'b0;

  logic       m_ov, s_ov, m_no, s_no, m_sat, s_sat, m_one, s_one;
  logic [3:0] c_ov, c_no, c_one;
  logic [1:0] c_sat;

  always #5 clk = ~clk;

  seq_detect_counter #(.PATTERN(4'b1011), .CNT_W(4), .OVERLAP(1'b1)) u_ov (
    .clk(clk), .res(res), .din(din), .en(en), .match(m_ov), .count(c_ov), .sat(s_ov));
  seq_detect_counter #(.PATTERN(4'b1011), .CNT_W(4), .OVERLAP(1'b0)) u_no (
    .clk(clk), .res(res), .din(din), .en(en), .match(m_no), .count(c_no), .sat(s_no));
  seq_detect_counter #(.PATTERN(4'b1011), .CNT_W(2), .OVERLAP(1'b1)) u_sat (
    .clk(clk), .res(res), .din(din), .en(en), .match(m_sat), .count(c_sat), .sat(s_sat));
  seq_detect_counter #(.PATTERN(4'b1111), .CNT_W(4), .OVERLAP(1'b1)) u_one (
    .clk(clk), .res(res), .din(din), .en(en), .match(m_one), .count(c_one), .sat(s_one));

  typedef struct {
    int         sel;
    logic       m;
    logic [3:0] c;
    logic       s;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic drive(input logic r, input logic e, input logic d, input int sel,
                       input logic m, input logic [3:0] c, input logic s, input string name);
    exp_t x;
    @(negedge clk);
    res = r;
    en  = e;
    din = d;
    x.sel = sel; x.m = m; x.c = c; x.s = s; x.name = name;
    sb_q.push_back(x);
  endtask

  task automatic rst(input int sel, input string name);
    drive(1'b1, 1'b0, 1'b0, sel, 1'b0, 4'd0, 1'b0, name);
  endtask

  task automatic b(input logic d, input int sel, input logic m, input logic [3:0] c,
                   input logic s, input string name);
    drive(1'b0, 1'b1, d, sel, m, c, s, name);
  endtask

  // Monitor: outputs settle after the edge that consumed the pushed stimulus.
  always @(posedge clk) begin
    exp_t       x;
    logic       am, as;
    logic [3:0] ac;
    #1;
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      case (x.sel)
        0: begin am = m_ov;  ac = c_ov;            as = s_ov;  end
        1: begin am = m_no;  ac = c_no;            as = s_no;  end
        2: begin am = m_sat; ac = {2'b00, c_sat};  as = s_sat; end
        3: begin am = m_one; ac = c_one;           as = s_one; end
        default: begin am = 1'bx; ac = 4'bxxxx; as = 1'bx; end
      endcase
      checks++;
      if ({am, ac, as} !== {x.m, x.c, x.s}) begin
        errors++;
        $display("FAIL %s: match/count/sat got %0b/%0d/%0b, expected %0b/%0d/%0b",
                 x.name, am, ac, as, x.m, x.c, x.s);
      end
    end
  end

  initial begin
    // Overlapping 1011: matches after bits 4 and 7.
    rst(0, "ov_reset");
    b(1'b1, 0, 1'b0, 4'd0, 1'b0, "ov_b1");
    b(1'b0, 0, 1'b0, 4'd0, 1'b0, "ov_b2");
    b(1'b1, 0, 1'b0, 4'd0, 1'b0, "ov_b3");
    b(1'b1, 0, 1'b1, 4'd1, 1'b0, "ov_b4");
    b(1'b0, 0, 1'b0, 4'd1, 1'b0, "ov_b5");
    b(1'b1, 0, 1'b0, 4'd1, 1'b0, "ov_b6");
    b(1'b1, 0, 1'b1, 4'd2, 1'b0, "ov_b7");

    // Same stream, non-overlapping: only one match.
    rst(1, "no_reset");
    b(1'b1, 1, 1'b0, 4'd0, 1'b0, "no_b1");
    b(1'b0, 1, 1'b0, 4'd0, 1'b0, "no_b2");
    b(1'b1, 1, 1'b0, 4'd0, 1'b0, "no_b3");
    b(1'b1, 1, 1'b1, 4'd1, 1'b0, "no_b4");
    b(1'b0, 1, 1'b0, 4'd1, 1'b0, "no_b5");
    b(1'b1, 1, 1'b0, 4'd1, 1'b0, "no_b6");
    b(1'b1, 1, 1'b0, 4'd1, 1'b0, "no_b7");

    // Fallback 11011.
    rst(0, "fb_reset");
    b(1'b1, 0, 1'b0, 4'd0, 1'b0, "fb_b1");
    b(1'b1, 0, 1'b0, 4'd0, 1'b0, "fb_b2");
    b(1'b0, 0, 1'b0, 4'd0, 1'b0, "fb_b3");
    b(1'b1, 0, 1'b0, 4'd0, 1'b0, "fb_b4");
    b(1'b1, 0, 1'b1, 4'd1, 1'b0, "fb_b5");

    // Enable gap keeps the partial prefix.
    rst(0, "gap_reset");
    b(1'b1, 0, 1'b0, 4'd0, 1'b0, "gap_b1");
    b(1'b0, 0, 1'b0, 4'd0, 1'b0, "gap_b2");
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 4'd0, 1'b0, "gap_hold");
    b(1'b1, 0, 1'b0, 4'd0, 1'b0, "gap_b3");
    b(1'b1, 0, 1'b1, 4'd1, 1'b0, "gap_b4");

    // Reset mid-sequence, on the very edge that would complete the pattern.
    rst(0, "mid_reset0");
    b(1'b1, 0, 1'b0, 4'd0, 1'b0, "mid_b1");
    b(1'b0, 0, 1'b0, 4'd0, 1'b0, "mid_b2");
    b(1'b1, 0, 1'b0, 4'd0, 1'b0, "mid_b3");
    drive(1'b1, 1'b1, 1'b1, 0, 1'b0, 4'd0, 1'b0, "mid_res_priority");
    b(1'b1, 0, 1'b0, 4'd0, 1'b0, "mid_after1");
    b(1'b1, 0, 1'b0, 4'd0, 1'b0, "mid_r1");
    b(1'b0, 0, 1'b0, 4'd0, 1'b0, "mid_r2");
    b(1'b1, 0, 1'b0, 4'd0, 1'b0, "mid_r3");
    b(1'b1, 0, 1'b1, 4'd1, 1'b0, "mid_r4");

    // Saturation with a 2-bit counter: count 1,2,3,3,3; sat from the third match.
    rst(2, "sat_reset");
    for (int g = 0; g < 5; g++) begin
      logic [3:0] cp, cn;
      cp = (g > 3) ? 4'd3 : 4'(g);
      cn = (g + 1 > 3) ? 4'd3 : 4'(g + 1);
      b(1'b1, 2, 1'b0, cp, (g >= 3), "sat_grp_b1");
      b(1'b0, 2, 1'b0, cp, (g >= 3), "sat_grp_b2");
      b(1'b1, 2, 1'b0, cp, (g >= 3), "sat_grp_b3");
      b(1'b1, 2, 1'b1, cn, (g >= 2), "sat_grp_match");
    end
    rst(2, "sat_clear");

    // Pattern 1111: back-to-back matches, held border across an enable gap.
    rst(3, "ones_reset");
    b(1'b1, 3, 1'b0, 4'd0, 1'b0, "ones_b1");
    b(1'b1, 3, 1'b0, 4'd0, 1'b0, "ones_b2");
    b(1'b1, 3, 1'b0, 4'd0, 1'b0, "ones_b3");
    b(1'b1, 3, 1'b1, 4'd1, 1'b0, "ones_m1");
    b(1'b1, 3, 1'b1, 4'd2, 1'b0, "ones_m2");
    b(1'b1, 3, 1'b1, 4'd3, 1'b0, "ones_m3");
    drive(1'b0, 1'b0, 1'b1, 3, 1'b0, 4'd3, 1'b0, "ones_hold");
    b(1'b1, 3, 1'b1, 4'd4, 1'b0, "ones_m4");
    b(1'b0, 3, 1'b0, 4'd4, 1'b0, "ones_break");

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
